mips_hazard_unit: RTL and testbench
===================================

# mips_hazard_unit

Parametrised scoreboard-based hazard and forwarding controller for the pipelined MIPS core. It tracks the destination of every in-flight instruction from EX to writeback, and it generates the PC/IF-ID stall, IF-ID flush, ID-EX bubble and per-operand forwarding selects for the instruction in ID. Saturating stall and flush counters are included for performance bring-up. It sits beside the datapath. The datapath feeds the controller's decoded ID-stage fields into it, and its outputs drive the `flopenr` enables and the operand muxes.

## Interface
- `NSTAGE`, 3, number of tracked stages after ID (1=EX … NSTAGE=WB); legal range 2..8
- `REGBITS`, 5, register-address width
- `ALU_AVAIL`, 1, first stage whose output bus carries a non-load result
- `LOAD_AVAIL`, 2, first stage whose output bus carries load data; must be ≥ `ALU_AVAIL`
- `FWD_EN`, 1, 1 = forwarding enabled; 0 = stall on every in-flight match
- `CNTW`, 16, performance counter width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  REGBITS  source register addresses
- `id_use_rs`, `id_use_rt`  in  1  operand is actually read
- `id_regwrite`  in  1  ID instruction writes a register
- `id_load`  in  1  ID instruction is a load (memtoreg)
- `id_wa`  in  REGBITS  final write address (after regdst/jal muxing)
- `redirect`  in  1  branch taken / jump / jr resolved this cycle
- `cnt_clr`  in  1  synchronous clear of both counters
- `stall`  out  1  hold PC and IF/ID (drives `~en`)
- `flush_ifid`  out  1  load NOP into IF/ID
- `bubble_idex`  out  1  ID/EX receives a bubble
- `fwd_a`, `fwd_b`  out  4  0 = regfile, k = result bus of stage k
- `stall_cnt`, `flush_cnt`  out  CNTW  saturating event counters

## Operation
- Scoreboard: `NSTAGE` entries `{v, wr, ld, wa}`. A producer is *live* when `v & wr & wa != 0`.
- Match: source S (rs or rt) matches entry k when `id_use_S`, entry k is live, and `wa == S`. Register 0 never matches.
- For each source, the youngest matching stage (lowest k) is selected.
  - If `FWD_EN=1` and k ≥ (`ld` ? `LOAD_AVAIL` : `ALU_AVAIL`): `fwd_S = k`.
  - Otherwise the source is blocked.
  - If `FWD_EN=0`, any match with k < `NSTAGE` is blocked. A match at `NSTAGE` gives `fwd_S = NSTAGE`, because the regfile is not write-through.
- `stall = id_valid & (rs blocked | rt blocked) & ~redirect`.
- `flush_ifid = redirect`.
- `bubble_idex = stall | redirect`.
- `fwd_*` = 0 whenever `id_valid=0` or there is no match.
- Shift on every clock edge:
  - Entry 1 takes `{id_valid & ~bubble_idex, id_regwrite, id_load, id_wa}`.
  - Entry k takes entry k−1.
  - The scoreboard never stalls; only IF and ID hold.
- Counters:
  - `stall_cnt` increments on each cycle with `stall=1`.
  - `flush_cnt` increments on each cycle with `redirect=1`.
  - Both saturate at all-ones.
  - `cnt_clr` clears both and has priority over increment.

## Timing
- Reset (asynchronous, active-low): all entry `v` bits = 0 and counters = 0. `stall`, `flush_ifid`, `bubble_idex` and `fwd_*` are therefore 0 from reset assertion onward. Reset in the middle of a stall drops the stall immediately.
- `stall`, `flush_ifid`, `bubble_idex` and `fwd_*` are combinational from the ID inputs and the registered scoreboard, with zero latency. Counters update on the following edge.
- Load-use with default parameters: exactly one stall cycle, after which `fwd = 2`.
- With `FWD_EN=0`: a dependent instruction stalls until the producer reaches `NSTAGE`, i.e. `NSTAGE−k` cycles for a producer in stage k.
- Simultaneous `redirect` and blocked source: redirect wins. `stall=0` and the ID instruction becomes a bubble.
- Both sources blocked count as one stall cycle.
- A repeated `wa` in several stages: the youngest entry always wins.

## Test plan
- Reset asserted mid-stream with live entries → all outputs 0 within the same cycle; after release, `stall_cnt=0`.
- `add $3,$1,$2` then `sub $4,$3,$5` (defaults) → no stall; `fwd_a=1` on the sub in ID; `fwd_b=0`.
- `lw $3,0($1)` then `add $4,$3,$3` → one cycle with `stall=1` and `bubble_idex=1`, then `fwd_a=fwd_b=2`; `stall_cnt=1`.
- `FWD_EN=0`: `addi $7,$0,5` then `or $8,$7,$7` → `stall` high for 2 cycles, then `fwd_a=3`.
- `lw $3`, dependent instruction in ID, `redirect=1` in the same cycle → `stall=0`, `flush_ifid=1`, `bubble_idex=1`; entry 1 `v=0` next cycle; `flush_cnt=1`.
- Writes to `$0` followed by a reader of `$0` → no match, `fwd=0`, no stall. With `CNTW=2` and 5 stall cycles, `stall_cnt` saturates at 3; `cnt_clr` returns it to 0.

Source files
------------

// File: rtl/mips_hazard_unit.sv
// Scoreboard-based hazard and forwarding controller for the pipelined MIPS core.
// Tracks in-flight destinations from EX to WB and derives stall/flush/bubble and operand forward selects.
module mips_hazard_unit #(
  parameter int NSTAGE     = 3,
  parameter int REGBITS    = 5,
  parameter int ALU_AVAIL  = 1,
  parameter int LOAD_AVAIL = 2,
  parameter int FWD_EN     = 1,
  parameter int CNTW       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_regwrite,
  input  logic               id_load,
  input  logic [REGBITS-1:0] id_wa,
  input  logic               redirect,
  input  logic               cnt_clr,
  output logic               stall,
  output logic               flush_ifid,
  output logic               bubble_idex,
  output logic [3:0]         fwd_a,
  output logic [3:0]         fwd_b,
  output logic [CNTW-1:0]    stall_cnt,
  output logic [CNTW-1:0]    flush_cnt
);

  logic [NSTAGE:1]    v_q, v_d;
  logic [NSTAGE:1]    wr_q, wr_d;
  logic [NSTAGE:1]    ld_q, ld_d;
  logic [REGBITS-1:0] wa_q [1:NSTAGE];
  logic [REGBITS-1:0] wa_d [1:NSTAGE];

  logic [NSTAGE:1]    match_rs, match_rt;
  logic [4:0]         res_rs, res_rt;
  logic [CNTW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]    flush_cnt_q, flush_cnt_d;

  // Picks the youngest matching stage and decides whether its result is already on a bus.
  // Returns {blocked, fwd_sel}; a blocked source reports select 0.
  function automatic logic [4:0] resolve(input logic [NSTAGE:1] m, input logic [NSTAGE:1] ld);
    int   k_sel;
    logic hit;
    logic ld_sel;
    logic blk;
    k_sel  = 0;
    hit    = 1'b0;
    ld_sel = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (m[k]) begin
        k_sel  = k;
        ld_sel = ld[k];
        hit    = 1'b1;
      end
    end
    blk = 1'b0;
    if (hit) begin
      if (FWD_EN != 0) blk = ld_sel ? (k_sel < LOAD_AVAIL) : (k_sel < ALU_AVAIL);
      else             blk = (k_sel < NSTAGE);
    end
    return {blk, blk ? 4'd0 : 4'(k_sel)};
  endfunction

  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int k = 1; k <= NSTAGE; k++) begin
      // wa != 0 keeps $0 from ever matching, even when a source reads $0.
      match_rs[k] = id_use_rs & v_q[k] & wr_q[k] & (wa_q[k] != '0) & (wa_q[k] == id_rs);
      match_rt[k] = id_use_rt & v_q[k] & wr_q[k] & (wa_q[k] != '0) & (wa_q[k] == id_rt);
    end
    res_rs = resolve(match_rs, ld_q);
    res_rt = resolve(match_rt, ld_q);
  end

  // The scoreboard clears asynchronously; flush is additionally gated so it is quiet during reset.
  always_comb begin
    flush_ifid  = redirect & reset;
    stall       = reset & id_valid & (res_rs[4] | res_rt[4]) & ~redirect;
    bubble_idex = stall | flush_ifid;
    fwd_a       = id_valid ? res_rs[3:0] : 4'd0;
    fwd_b       = id_valid ? res_rt[3:0] : 4'd0;
  end

  always_comb begin
    v_d     = '0;
    wr_d    = '0;
    ld_d    = '0;
    v_d[1]  = id_valid & ~bubble_idex;
    wr_d[1] = id_regwrite;
    ld_d[1] = id_load;
    wa_d[1] = id_wa;
    for (int k = 2; k <= NSTAGE; k++) begin
      v_d[k]  = v_q[k-1];
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
      wa_d[k] = wa_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + CNTW'(1);
      if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Addresses are qualified by v, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= NSTAGE; k++) wa_q[k] <= wa_d[k];
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit: a forwarding instance (defaults) and a no-forward instance with 2-bit counters,
// both checked every cycle against an instruction-age model plus directed scenarios.
module tb_mips_hazard_unit;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_load, redirect, cnt_clr;
  logic [4:0] id_rs, id_rt, id_wa;
  logic       stall0, flush0, bub0, stall1, flush1, bub1;
  logic [3:0] fa0, fb0, fa1, fb1;
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  mips_hazard_unit u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_load(id_load),
    .id_wa(id_wa), .redirect(redirect), .cnt_clr(cnt_clr), .stall(stall0), .flush_ifid(flush0),
    .bubble_idex(bub0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

  mips_hazard_unit #(.FWD_EN(0), .CNTW(2)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite), .id_load(id_load),
    .id_wa(id_wa), .redirect(redirect), .cnt_clr(cnt_clr), .stall(stall1), .flush_ifid(flush1),
    .bubble_idex(bub1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  // Model: for each instance, the instructions issued 1..NS cycles ago (age = stage number).
  bit       m_v  [2][1:NS];
  bit       m_wr [2][1:NS];
  bit       m_ld [2][1:NS];
  int       m_wa [2][1:NS];
  int       m_sc [2];
  int       m_fc [2];
  int       e_stall [2];
  int       e_fa [2];
  int       e_fb [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int a = 1; a <= NS; a++) begin
        m_v[i][a] = 0; m_wr[i][a] = 0; m_ld[i][a] = 0; m_wa[i][a] = 0;
      end
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endtask

  // A result of age a is usable once a reaches the stage where it appears on a bus.
  task automatic src_eval(input int i, input bit use_s, input int s, output int fwd, output bit blk);
    int ready;
    bit found;
    fwd = 0;
    blk = 0;
    found = 0;
    if (use_s && s != 0) begin
      for (int a = 1; a <= NS; a++) begin
        if (!found && m_v[i][a] && m_wr[i][a] && m_wa[i][a] == s) begin
          found = 1;
          ready = (i == 0) ? (m_ld[i][a] ? 2 : 1) : NS;
          if (a >= ready) fwd = a;
          else blk = 1;
        end
      end
    end
  endtask

  task automatic predict(input int i);
    int fa, fb;
    bit ba, bb;
    src_eval(i, id_use_rs, int'(id_rs), fa, ba);
    src_eval(i, id_use_rt, int'(id_rt), fb, bb);
    e_stall[i] = (id_valid && (ba || bb) && !redirect) ? 1 : 0;
    e_fa[i] = id_valid ? fa : 0;
    e_fb[i] = id_valid ? fb : 0;
  endtask

  task automatic advance(input int i);
    int cmax;
    cmax = (i == 0) ? 65535 : 3;
    for (int a = NS; a >= 2; a--) begin
      m_v[i][a] = m_v[i][a-1]; m_wr[i][a] = m_wr[i][a-1];
      m_ld[i][a] = m_ld[i][a-1]; m_wa[i][a] = m_wa[i][a-1];
    end
    m_v[i][1]  = id_valid && !(e_stall[i] != 0 || redirect);
    m_wr[i][1] = id_regwrite;
    m_ld[i][1] = id_load;
    m_wa[i][1] = int'(id_wa);
    if (cnt_clr) begin
      m_sc[i] = 0;
      m_fc[i] = 0;
    end else begin
      if (e_stall[i] != 0 && m_sc[i] < cmax) m_sc[i]++;
      if (redirect && m_fc[i] < cmax) m_fc[i]++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    predict(0);
    predict(1);
    chk("stall0", stall0, e_stall[0]);
    chk("bubble0", bub0, (e_stall[0] != 0 || redirect) ? 1 : 0);
    chk("flush0", flush0, redirect);
    chk("fwd_a0", fa0, e_fa[0]);
    chk("fwd_b0", fb0, e_fb[0]);
    chk("stall_cnt0", sc0, m_sc[0]);
    chk("flush_cnt0", fc0, m_fc[0]);
    chk("stall1", stall1, e_stall[1]);
    chk("bubble1", bub1, (e_stall[1] != 0 || redirect) ? 1 : 0);
    chk("flush1", flush1, redirect);
    chk("fwd_a1", fa1, e_fa[1]);
    chk("fwd_b1", fb1, e_fb[1]);
    chk("stall_cnt1", sc1, m_sc[1]);
    chk("flush_cnt1", fc1, m_fc[1]);
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask

  task automatic put(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                     input bit rw, input bit ld, input int wa);
    id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
    id_regwrite = rw; id_load = ld; id_wa = 5'(wa);
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (NS) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall0"}, stall0, 0);
    chk({tag, "_flush0"}, flush0, 0);
    chk({tag, "_bub0"}, bub0, 0);
    chk({tag, "_fa0"}, fa0, 0);
    chk({tag, "_fb0"}, fb0, 0);
    chk({tag, "_stall1"}, stall1, 0);
    chk({tag, "_flush1"}, flush1, 0);
    chk({tag, "_bub1"}, bub1, 0);
    chk({tag, "_sc0"}, sc0, 0);
    chk({tag, "_sc1"}, sc1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    redirect = 1'b0;
    cnt_clr  = 1'b0;
    model_clear();
    // Reset held with an active instruction and redirect: everything must read 0.
    put(1, 1, 1, 2, 1, 1, 0, 3);
    redirect = 1'b1;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    redirect = 1'b0;
    reset = 1'b1;
    nop();
    cycle();

    // add $3,$1,$2 ; sub $4,$3,$5
    put(1, 1, 1, 2, 1, 1, 0, 3); cycle();
    put(1, 3, 1, 5, 1, 1, 0, 4); #1;
    chk("addsub_fa", fa0, 1);
    chk("addsub_fb", fb0, 0);
    chk("addsub_stall", stall0, 0);
    cycle();
    drain();

    // lw $3,0($1) ; add $4,$3,$3
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    put(1, 1, 1, 0, 0, 1, 1, 3); cycle();
    put(1, 3, 1, 3, 1, 1, 0, 4); #1;
    chk("lu_stall", stall0, 1);
    chk("lu_bubble", bub0, 1);
    cycle(); #1;
    chk("lu_stall_after", stall0, 0);
    chk("lu_fa", fa0, 2);
    chk("lu_fb", fb0, 2);
    cycle();
    nop(); #1;
    chk("lu_stall_cnt", sc0, 1);
    drain();

    // No forwarding: addi $7,$0,5 ; or $8,$7,$7
    put(1, 0, 1, 0, 0, 1, 0, 7); cycle();
    put(1, 7, 1, 7, 1, 1, 0, 8); #1;
    chk("nf_stall_c1", stall1, 1);
    chk("nf_fwd_on_fa", fa0, 1);
    cycle(); #1;
    chk("nf_stall_c2", stall1, 1);
    cycle(); #1;
    chk("nf_stall_c3", stall1, 0);
    chk("nf_fa", fa1, 3);
    chk("nf_fb", fb1, 3);
    cycle();
    drain();

    // lw $3 ; dependent add $4,$3,$3 together with redirect
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    put(1, 1, 1, 0, 0, 1, 1, 3); cycle();
    put(1, 3, 1, 3, 1, 1, 0, 4); redirect = 1'b1; #1;
    chk("rd_stall", stall0, 0);
    chk("rd_flush", flush0, 1);
    chk("rd_bubble", bub0, 1);
    cycle();
    redirect = 1'b0;
    put(1, 4, 1, 0, 0, 0, 0, 0); #1;
    chk("rd_entry1_dead_fa", fa0, 0);
    chk("rd_entry1_dead_stall", stall0, 0);
    chk("rd_flush_cnt", fc0, 1);
    cycle();
    drain();

    // Writes to $0 then a reader of $0
    put(1, 1, 1, 1, 1, 1, 0, 0); cycle();
    put(1, 0, 1, 0, 1, 1, 0, 5); #1;
    chk("r0_fa", fa0, 0);
    chk("r0_fb", fb0, 0);
    chk("r0_stall0", stall0, 0);
    chk("r0_stall1", stall1, 0);
    cycle();
    drain();

    // Saturation of the 2-bit stall counter: six no-forward stall cycles
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    repeat (3) begin
      put(1, 0, 1, 0, 0, 1, 0, 7); cycle();
      put(1, 7, 1, 7, 1, 1, 0, 8); repeat (3) cycle();
      drain();
    end
    chk("sat_stall_cnt", sc1, 3);
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0; #1;
    chk("sat_clr", sc1, 0);

    // Randomized traffic over a small register set to provoke many hazards
    for (int n = 0; n < 400; n++) begin
      put(($urandom % 8) != 0, $urandom_range(0, 3), $urandom % 2, $urandom_range(0, 3), $urandom % 2,
          $urandom % 2, $urandom % 2, $urandom_range(0, 3));
      redirect = (($urandom % 8) == 0);
      cnt_clr  = (($urandom % 50) == 0);
      cycle();
    end
    redirect = 1'b0;
    cnt_clr  = 1'b0;

    // Reset in the middle of a load-use stall
    put(1, 1, 1, 0, 0, 1, 1, 3); cycle();
    put(1, 3, 1, 3, 1, 1, 0, 4); #1;
    chk("mid_stall_before", stall0, 1);
    redirect = 1'b1;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_clear();
    redirect = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    nop();
    cycle(); #1;
    chk("post_reset_sc0", sc0, 0);
    chk("post_reset_fc0", fc0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
